// File: rtl/pc_source_pkg.sv
// Shared constants and types for the registered PC-source selector.
// Source indices follow the multicycle datapath's PCSource encoding.
package pc_source_pkg;

   localparam int SRC_PC4    = 0;
   localparam int SRC_ALUOUT = 1;
   localparam int SRC_JUMP   = 2;
   localparam int SRC_EPC    = 3;
   localparam int SRC_SEXT   = 4;
   localparam int SRC_MEM    = 5;

   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_00FF;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/mux_n.sv
// Combinational WIDTH x N_SRC selector over a flattened source bus.
// Out-of-range selector codes yield zero.
module mux_n #(
   parameter int WIDTH = 32,
   parameter int N_SRC = 6,
   parameter int SEL_W = $clog2(N_SRC)
) (
   input  logic [N_SRC*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]       selector,
   output logic [WIDTH-1:0]       data_out
);

   always_comb begin
      data_out = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (selector == SEL_W'(k))
            data_out = data_in[k*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/pc_source_reg.sv
// Registered next-PC selector with exception redirect and hold window.
// Optional target alignment check: define PC_SOURCE_ALIGN_CHECK_EN.
module pc_source_reg
   import pc_source_pkg::*;
#(
   parameter int          WIDTH       = 32,
   parameter int          N_SRC       = 6,
   parameter int          SEL_W       = $clog2(N_SRC),
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
   parameter int          HOLD_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_SRC*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]       selector,
   input  logic                   load,
   input  logic                   cond_load,
   input  logic                   cond,
   input  logic                   exc_req,
   input  logic                   err_clr,
   output logic [WIDTH-1:0]       data_out,
   output logic                   load_done,
   output logic                   busy,
   output logic                   sel_err,
   output logic                   misalign
);

   localparam logic [3:0]       HOLD_INIT = 4'(HOLD_CYCLES);
   localparam logic [SEL_W:0]   NSRC_L    = (SEL_W+1)'(N_SRC);
   localparam logic [WIDTH-1:0] RST_PC    = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] EXC_PC    = WIDTH'(EXC_VECTOR);
   localparam logic             HOLD_EN   = (HOLD_CYCLES > 0);

   state_t           state;
   logic [3:0]       cnt;
   logic [WIDTH-1:0] target;
   logic             wr;
   logic             sel_bad;
   logic             err_new;

   mux_n #(
      .WIDTH (WIDTH),
      .N_SRC (N_SRC),
      .SEL_W (SEL_W)
   ) u_mux (
      .data_in  (data_in),
      .selector (selector),
      .data_out (target)
   );

   assign wr      = load | (cond_load & cond);
   assign sel_bad = {1'b0, selector} >= NSRC_L;
   assign err_new = (state == IDLE) & ~exc_req & wr & sel_bad;

`ifdef PC_SOURCE_ALIGN_CHECK_EN
   logic mis_q;
   logic mis_new;

   assign mis_new  = (state == IDLE) & ~exc_req & wr & ~sel_bad
                   & (|target[1:0]);
   assign misalign = mis_q;

   always_ff @(posedge clk) begin
      if (reset)
         mis_q <= 1'b0;
      else if (mis_new)
         mis_q <= 1'b1;
      else if (err_clr)
         mis_q <= 1'b0;
   end
`else
   logic mis_new;

   assign mis_new  = 1'b0;
   assign misalign = 1'b0;
`endif

   // A new error in the clearing cycle must survive the clear.
   always_ff @(posedge clk) begin
      if (reset)
         sel_err <= 1'b0;
      else if (err_new)
         sel_err <= 1'b1;
      else if (err_clr)
         sel_err <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         data_out  <= RST_PC;
         cnt       <= '0;
         load_done <= 1'b0;
         busy      <= 1'b0;
      end else begin
         load_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (exc_req || mis_new) begin
                  data_out <= EXC_PC;
                  cnt      <= HOLD_INIT;
                  state    <= HOLD_EN ? HOLD : IDLE;
                  busy     <= HOLD_EN;
               end else if (wr && !sel_bad) begin
                  data_out  <= target;
                  load_done <= 1'b1;
               end
            end
            HOLD: begin
               if (exc_req) begin
                  data_out <= EXC_PC;
                  cnt      <= HOLD_INIT;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt <= 4'd1) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_source_reg.sv
// Scoreboarded bench for pc_source_reg (N_SRC=6, HOLD_CYCLES=2).
// Alignment scenario runs only with PC_SOURCE_ALIGN_CHECK_EN.
module tb_pc_source_reg;

   localparam int W  = 32;
   localparam int NS = 6;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [NS*W-1:0] data_in;
   logic [SW-1:0] selector;
   logic          load, cond_load, cond, exc_req, err_clr;
   logic [W-1:0]  data_out;
   logic          load_done, busy, sel_err, misalign;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       rst, ld, cl, c, exc, clr;
      logic [2:0] sel;
      logic [31:0] pc;
      logic [3:0] flg;
   } stim_t;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  flg;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pc_source_reg #(
      .WIDTH       (W),
      .N_SRC       (NS),
      .SEL_W       (SW),
      .RESET_VALUE (32'h0000_0000),
      .EXC_VECTOR  (32'h0000_00FF),
      .HOLD_CYCLES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .selector  (selector),
      .load      (load),
      .cond_load (cond_load),
      .cond      (cond),
      .exc_req   (exc_req),
      .err_clr   (err_clr),
      .data_out  (data_out),
      .load_done (load_done),
      .busy      (busy),
      .sel_err   (sel_err),
      .misalign  (misalign)
   );

   // flg = {load_done, busy, sel_err, misalign}
   function automatic stim_t mk(logic rst, logic ld, logic cl,
                                logic c, logic exc, logic clr,
                                logic [2:0] sel, logic [31:0] pc,
                                logic [3:0] flg);
      stim_t s;
      s.rst = rst; s.ld = ld; s.cl = cl; s.c = c;
      s.exc = exc; s.clr = clr; s.sel = sel;
      s.pc = pc; s.flg = flg;
      return s;
   endfunction

   task automatic drive(stim_t s);
      reset     = s.rst;
      load      = s.ld;
      cond_load = s.cl;
      cond      = s.c;
      exc_req   = s.exc;
      err_clr   = s.clr;
      selector  = s.sel;
      sb.push_back('{s.pc, s.flg});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(1,0,0,0,0,0,3'd0,32'h0000_0000,4'b0000));
      t.push_back(mk(0,0,0,0,0,0,3'd0,32'h0000_0000,4'b0000));
      foreach (t[i]) begin
         drive(t[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if (data_out !== e.pc) begin
            n_err++;
            $display("FAIL reset[%0d] pc got %h want %h", i, data_out, e.pc);
         end
         n_cmp++;
         if ({load_done, busy, sel_err, misalign} !== e.flg) begin
            n_err++;
            $display("FAIL reset[%0d] flags got %b want %b", i,
                     {load_done, busy, sel_err, misalign}, e.flg);
         end
      end
   endtask

   task automatic test_load();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(0,1,0,0,0,0,3'd1,32'h1000_0004,4'b1000));
      t.push_back(mk(0,0,0,0,0,0,3'd1,32'h1000_0004,4'b0000));
      t.push_back(mk(0,0,1,0,0,0,3'd2,32'h1000_0004,4'b0000));
      t.push_back(mk(0,0,1,1,0,0,3'd2,32'h1000_0008,4'b1000));
      t.push_back(mk(0,1,1,0,0,0,3'd3,32'h1000_000C,4'b1000));
      t.push_back(mk(0,0,0,1,0,0,3'd4,32'h1000_000C,4'b0000));
      foreach (t[i]) begin
         drive(t[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if (data_out !== e.pc) begin
            n_err++;
            $display("FAIL load[%0d] pc got %h want %h", i, data_out, e.pc);
         end
         n_cmp++;
         if ({load_done, busy, sel_err, misalign} !== e.flg) begin
            n_err++;
            $display("FAIL load[%0d] flags got %b want %b", i,
                     {load_done, busy, sel_err, misalign}, e.flg);
         end
      end
   endtask

   task automatic test_exception();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(0,0,0,0,1,0,3'd0,32'h0000_00FF,4'b0100));
      t.push_back(mk(0,1,0,0,0,0,3'd0,32'h0000_00FF,4'b0100));
      t.push_back(mk(0,1,0,0,0,0,3'd7,32'h0000_00FF,4'b0000));
      t.push_back(mk(0,1,0,0,0,0,3'd0,32'h1000_0000,4'b1000));
      foreach (t[i]) begin
         drive(t[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if (data_out !== e.pc) begin
            n_err++;
            $display("FAIL exc[%0d] pc got %h want %h", i, data_out, e.pc);
         end
         n_cmp++;
         if ({load_done, busy, sel_err, misalign} !== e.flg) begin
            n_err++;
            $display("FAIL exc[%0d] flags got %b want %b", i,
                     {load_done, busy, sel_err, misalign}, e.flg);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(0,0,0,0,1,0,3'd0,32'h0000_00FF,4'b0100));
      t.push_back(mk(0,0,0,0,1,0,3'd0,32'h0000_00FF,4'b0100));
      t.push_back(mk(0,1,0,0,0,0,3'd1,32'h0000_00FF,4'b0100));
      t.push_back(mk(0,1,0,0,0,0,3'd1,32'h0000_00FF,4'b0000));
      t.push_back(mk(0,1,0,0,0,0,3'd2,32'h1000_0008,4'b1000));
      t.push_back(mk(0,0,1,1,0,0,3'd3,32'h1000_000C,4'b1000));
      foreach (t[i]) begin
         drive(t[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if (data_out !== e.pc) begin
            n_err++;
            $display("FAIL b2b[%0d] pc got %h want %h", i, data_out, e.pc);
         end
         n_cmp++;
         if ({load_done, busy, sel_err, misalign} !== e.flg) begin
            n_err++;
            $display("FAIL b2b[%0d] flags got %b want %b", i,
                     {load_done, busy, sel_err, misalign}, e.flg);
         end
      end
   endtask

   task automatic test_sel_err();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(0,1,0,0,0,0,3'd6,32'h1000_000C,4'b0010));
      t.push_back(mk(0,0,0,0,0,0,3'd6,32'h1000_000C,4'b0010));
      t.push_back(mk(0,1,0,0,0,1,3'd7,32'h1000_000C,4'b0010));
      t.push_back(mk(0,0,0,0,0,1,3'd0,32'h1000_000C,4'b0000));
      t.push_back(mk(0,0,1,0,0,0,3'd7,32'h1000_000C,4'b0000));
      t.push_back(mk(0,1,0,0,0,0,3'd4,32'h1000_0010,4'b1000));
      foreach (t[i]) begin
         drive(t[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if (data_out !== e.pc) begin
            n_err++;
            $display("FAIL selerr[%0d] pc got %h want %h", i, data_out, e.pc);
         end
         n_cmp++;
         if ({load_done, busy, sel_err, misalign} !== e.flg) begin
            n_err++;
            $display("FAIL selerr[%0d] flags got %b want %b", i,
                     {load_done, busy, sel_err, misalign}, e.flg);
         end
      end
   endtask

   task automatic test_reset_in_hold();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(0,0,0,0,1,0,3'd0,32'h0000_00FF,4'b0100));
      t.push_back(mk(1,1,0,0,0,0,3'd1,32'h0000_0000,4'b0000));
      t.push_back(mk(0,1,0,0,0,0,3'd5,32'h1000_0014,4'b1000));
      foreach (t[i]) begin
         drive(t[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if (data_out !== e.pc) begin
            n_err++;
            $display("FAIL rsthold[%0d] pc got %h want %h", i, data_out, e.pc);
         end
         n_cmp++;
         if ({load_done, busy, sel_err, misalign} !== e.flg) begin
            n_err++;
            $display("FAIL rsthold[%0d] flags got %b want %b", i,
                     {load_done, busy, sel_err, misalign}, e.flg);
         end
      end
   endtask

`ifdef PC_SOURCE_ALIGN_CHECK_EN
   task automatic test_align();
      stim_t t[$];
      exp_t  e;
      data_in[5*W +: W] = 32'h1000_0002;
      t.push_back(mk(0,1,0,0,0,0,3'd5,32'h0000_00FF,4'b0101));
      t.push_back(mk(0,0,0,0,0,0,3'd0,32'h0000_00FF,4'b0101));
      t.push_back(mk(0,0,0,0,0,1,3'd0,32'h0000_00FF,4'b0000));
      t.push_back(mk(0,1,0,0,0,0,3'd1,32'h1000_0004,4'b1000));
      foreach (t[i]) begin
         drive(t[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if (data_out !== e.pc) begin
            n_err++;
            $display("FAIL align[%0d] pc got %h want %h", i, data_out, e.pc);
         end
         n_cmp++;
         if ({load_done, busy, sel_err, misalign} !== e.flg) begin
            n_err++;
            $display("FAIL align[%0d] flags got %b want %b", i,
                     {load_done, busy, sel_err, misalign}, e.flg);
         end
      end
      data_in[5*W +: W] = 32'h1000_0014;
   endtask
`endif

   initial begin
      reset = 1'b1; load = 1'b0; cond_load = 1'b0; cond = 1'b0;
      exc_req = 1'b0; err_clr = 1'b0; selector = '0;
      for (int k = 0; k < NS; k++)
         data_in[k*W +: W] = 32'h1000_0000 + 32'(4*k);
      test_reset();
      test_load();
      test_exception();
      test_back_to_back();
      test_sel_err();
      test_reset_in_hold();
`ifdef PC_SOURCE_ALIGN_CHECK_EN
      test_align();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
